// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   - default clock frequency and baud rate
//   - calc_cpb(): clocks per serial bit (integer division, truncating)
//   - uart_state_t: FSM encoding shared by uart_tx and uart_rx
//   - frame constants: start bit level, stop bit level, data bits per frame
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int calc_cpb(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..CPB-1 and wraps.
//   clk     in   system clock
//   rst     in   synchronous active-high reset (count -> 0)
//   clr     in   synchronous clear (count -> 0)
//   bit_end out  high during the last clock of a bit period (count == CPB-1)
//   pre_end out  high one clock before bit_end (count == CPB-2); lets the
//                owner register a flag that lines up with bit_end
// CPB must be at least 2.
module uart_baud_cnt #(
  parameter int CPB = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] PRE  = CW'(CPB - 2);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign bit_end = (cnt_reg == LAST);
  assign pre_end = (cnt_reg == PRE);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register.
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   d_in     in   byte to send, sampled when valid_in && ready
//   valid_in in   send request
//   ready    out  holding register empty
//   tx       out  registered serial line, idle high
//   busy     out  FSM not in IDLE
//   done     out  high during the final clock of each stop bit
// The holding register lets the next byte be queued while a frame shifts,
// so a queued byte starts on the very edge the previous stop bit ends.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CPB = calc_cpb(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t state_reg;
  logic [7:0]  hold_reg;
  logic [7:0]  shift_reg;
  logic        hold_full_reg;
  logic [2:0]  bit_idx_reg;
  logic [2:0]  bit_idx_next;
  logic        tx_reg;
  logic        done_reg;
  logic        bit_end;
  logic        pre_end;
  logic        baud_clr;
  logic        accept;

  // Holding the counter clear in IDLE means it restarts at 0 on the edge
  // that enters START from IDLE; back-to-back frames just keep wrapping.
  assign baud_clr     = (state_reg == IDLE);
  assign accept       = valid_in && !hold_full_reg;
  assign bit_idx_next = bit_idx_reg + 3'd1;

  uart_baud_cnt #(
    .CPB(CPB)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (baud_clr),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      shift_reg     <= '0;
      hold_full_reg <= 1'b0;
      bit_idx_reg   <= '0;
      tx_reg        <= STOP_BIT;
      done_reg      <= 1'b0;
    end else begin
      // The counter reads CPB-2 one clock before the stop bit's last clock,
      // so setting done here makes it coincide with that last clock.
      done_reg <= (state_reg == STOP) && pre_end;

      case (state_reg)
        IDLE: begin
          tx_reg <= STOP_BIT;
          if (hold_full_reg) begin
            shift_reg     <= hold_reg;
            hold_full_reg <= 1'b0;
            state_reg     <= START;
            tx_reg        <= START_BIT;
          end
        end
        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == LAST_IDX) begin
              state_reg <= STOP;
              tx_reg    <= STOP_BIT;
            end else begin
              bit_idx_reg <= bit_idx_next;
              tx_reg      <= shift_reg[bit_idx_next];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (hold_full_reg) begin
              shift_reg     <= hold_reg;
              hold_full_reg <= 1'b0;
              state_reg     <= START;
              tx_reg        <= START_BIT;
            end else begin
              state_reg <= IDLE;
              tx_reg    <= STOP_BIT;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= STOP_BIT;
        end
      endcase

      // accept requires hold empty and every load above requires hold full,
      // so the two never touch hold_full_reg on the same edge.
      if (accept) begin
        hold_reg      <= d_in;
        hold_full_reg <= 1'b1;
      end
    end
  end

  assign ready = !hold_full_reg;
  assign tx    = tx_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + randomized bench for uart_tx at a small CPB.
// The reference model keeps a list of frames (byte, acceptance edge, start
// edge) and derives the expected line, busy, done and ready for every clock
// from frame arithmetic. A behavioural mid-bit sampler decodes tx back into
// bytes and compares them, in order, with the bytes that were accepted.
module tb_uart_tx;

  localparam int CLK_FREQ  = 1200;
  localparam int BAUD_RATE = 100;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready, tx, busy, done;

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .valid_in(valid_in),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model state.
  logic [7:0] fr_b [64];
  int         fr_a [64];
  int         fr_s [64];
  int         nfr = 0;
  int         prev_end = 0;
  logic       last_acc = 1'b0;
  logic [7:0] exp_rx [$];

  // Behavioural receiver state.
  logic       tx_prev = 1'b1;
  logic       rx_active = 1'b0;
  int         rx_t0 = 0;
  logic [7:0] rx_byte = 8'h00;
  int         ndone = 0;

  function automatic logic exp_tx(input int t);
    for (int i = 0; i < nfr; i++) begin
      if (t >= fr_s[i] && t < fr_s[i] + FRAME) begin
        int k;
        k = (t - fr_s[i]) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fr_b[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int t);
    for (int i = 0; i < nfr; i++)
      if (t >= fr_s[i] && t < fr_s[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_done(input int t);
    for (int i = 0; i < nfr; i++)
      if (t == fr_s[i] + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(input int t);
    for (int i = 0; i < nfr; i++)
      if (t >= fr_a[i] && t < fr_s[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock: update the model for the edge, then compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    last_acc = 1'b0;
    if (rst) begin
      for (int i = 0; i < nfr; i++)
        if (fr_s[i] + FRAME > cyc && exp_rx.size() > 0) void'(exp_rx.pop_back());
      nfr = 0;
      prev_end = 0;
      rx_active = 1'b0;
    end else if (valid_in && exp_ready(cyc - 1)) begin
      fr_b[nfr] = d_in;
      fr_a[nfr] = cyc;
      fr_s[nfr] = (cyc + 1 > prev_end) ? cyc + 1 : prev_end;
      prev_end  = fr_s[nfr] + FRAME;
      nfr++;
      exp_rx.push_back(d_in);
      last_acc = 1'b1;
    end
    #1;
    check("tx", {7'd0, tx}, {7'd0, exp_tx(cyc)});
    check("busy", {7'd0, busy}, {7'd0, exp_busy(cyc)});
    check("done", {7'd0, done}, {7'd0, exp_done(cyc)});
    check("ready", {7'd0, ready}, {7'd0, exp_ready(cyc)});
    if (done === 1'b1) ndone++;
    // Mid-bit sampler.
    if (!rx_active && tx_prev === 1'b1 && tx === 1'b0) begin
      rx_active = 1'b1;
      rx_t0 = cyc;
    end
    if (rx_active && ((cyc - rx_t0) % CPB) == CPB / 2) begin
      int idx;
      idx = (cyc - rx_t0) / CPB;
      if (idx == 0) begin
        check("rx_start", {7'd0, tx}, 8'h00);
      end else if (idx <= 8) begin
        rx_byte[idx-1] = tx;
      end else begin
        check("rx_stop", {7'd0, tx}, 8'h01);
        if (exp_rx.size() == 0) begin
          check("rx_extra", rx_byte, 8'hxx);
        end else begin
          check("rx_byte", rx_byte, exp_rx.pop_front());
        end
        rx_active = 1'b0;
      end
    end
    tx_prev = tx;
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    d_in = b;
    valid_in = 1'b1;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 3 * FRAME);
    if (!last_acc) check("send_timeout", 8'h00, 8'h01);
    $display("send %h accepted t=%0d start=%0d", b, cyc, fr_s[nfr-1]);
    valid_in = 1'b0;
    d_in = 8'($urandom);
  endtask

  task automatic run_idle();
    int guard;
    guard = 0;
    while ((cyc < prev_end + 2) && guard < 40 * FRAME) begin
      tick();
      guard++;
    end
    if (guard >= 40 * FRAME) check("idle_timeout", 8'h00, 8'h01);
  endtask

  initial begin
    int s, d0;
    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tx", {7'd0, tx}, 8'h01);
    check("rst_ready", {7'd0, ready}, 8'h01);
    check("rst_busy", {7'd0, busy}, 8'h00);

    // Single frame; latency from acceptance to start bit is one edge.
    repeat (4) tick();
    d0 = ndone;
    send(8'h46);
    tick();
    check("latency_tx", {7'd0, tx}, 8'h00);
    run_idle();
    check("done_count_46", 8'(ndone - d0), 8'd1);

    // Back-to-back frames.
    send(8'h50);
    send(8'h47);
    check("b2b_start", 8'(fr_s[nfr-1] - fr_s[nfr-2]), 8'(FRAME));
    run_idle();

    // Held byte plus an ignored request while the hold register is full.
    send(8'h47);
    send(8'h41);
    d_in = 8'hFF;
    valid_in = 1'b1;
    repeat (3 * CPB) tick();
    valid_in = 1'b0;
    run_idle();
    check("no_ff_queued", 8'(exp_rx.size()), 8'd0);

    // Reset in the middle of data bit 3.
    send(8'hA5);
    s = fr_s[nfr-1];
    while (cyc < s + 4 * CPB + CPB / 2 - 1) tick();
    rst = 1'b1;
    d0 = ndone;
    tick();
    rst = 1'b0;
    check("midrst_tx", {7'd0, tx}, 8'h01);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    check("midrst_ready", {7'd0, ready}, 8'h01);
    repeat (2 * FRAME) tick();
    check("midrst_nodone", 8'(ndone - d0), 8'd0);

    // Boundary bytes, then random bytes with random gaps.
    send(8'h00);
    send(8'hFF);
    run_idle();
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = $urandom_range(0, 2 * CPB);
      repeat (gap) tick();
      send(8'($urandom));
    end
    run_idle();
    check("rx_all_seen", 8'(exp_rx.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter, the transmit counterpart of uart_rx on the same serial link.
- Accepts bytes from on-chip logic over a valid/ready handshake.
- Buffers one byte in a holding register, so consecutive frames go out back-to-back with no idle gap.
- Serialises each byte onto tx at BAUD_RATE, derived from a single clock.
- Feeds the telemetry/navigation serial output and provides the stimulus source for uart_rx loopback benches.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- CPB (localparam), CLK_FREQ/BAUD_RATE with integer truncation (5208 at defaults), clocks per bit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d_in  in  8  byte to send; sampled only when valid_in && ready.
- valid_in  in  1  request to send d_in.
- ready  out  1  holding register empty; a byte is accepted on any edge where valid_in && ready.
- tx  out  1  serial line; registered, idle high.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse at completion of a stop bit.

Behaviour:
- Reset values: tx=1, ready=1, busy=0, done=0, FSM=IDLE, counters=0, holding register empty. Reset mid-frame forces tx=1 on the next edge; the partial frame is truncated and the held byte is discarded.
- Frame format: start bit 0, d[0]..d[7] LSB first, stop bit 1. Each bit holds exactly CPB clocks. Frame length is 10*CPB clocks.
- Handshake:
  - Acceptance at edge k sets hold_full, so ready=0 after edge k.
  - valid_in with ready=0 is ignored; the source must keep valid_in asserted until it sees ready.
  - d_in need not stay stable after acceptance.
- FSM states:
  - IDLE: if hold_full, load hold into shift_reg, clear hold_full (ready=1), go to START, tx=0. All of this happens on edge k+1 for a byte accepted at edge k, giving 1-cycle latency from acceptance to the tx falling edge.
  - START: tx=0 for CPB clocks, then DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx] for CPB clocks per bit. bit_idx is 3 bits. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CPB clocks. On the final clock of the stop bit, done=1 for that one cycle. Then:
    - if hold_full: load shift_reg, clear hold_full, go to START (tx=0 on the same edge, zero idle gap);
    - else: go to IDLE.
- Simultaneous events:
  - At the STOP→START transfer edge, ready was 0, so no new byte is accepted on that edge. ready=1 from the following cycle.
  - In IDLE with hold empty, acceptance and START entry never share an edge. Acceptance always goes through the holding register.
- Baud counter: width $clog2(CPB). Counts 0..CPB-1, then wraps to 0 with a bit-end strobe. It is cleared whenever the FSM enters START from IDLE.
- busy=1 in START, DATA and STOP.
- The tx value in each state is driven from a register, so there are no combinational glitches on the line.

Decomposition:
- Package uart_pkg holds:
  - default CLK_FREQ and BAUD_RATE;
  - a function returning CPB;
  - FSM state encoding (IDLE/START/DATA/STOP), shared with uart_rx;
  - frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
- One natural sub-module, uart_baud_cnt:
  - inputs: clk, rst, clr;
  - output: bit_end strobe;
  - parameter: CPB.

Test Plan:
- Reset, then send 0x46 → tx idle high, then falls 1 clock after acceptance; bit sequence 0,0,1,1,0,0,0,1,0,1, each 5208 clocks; done pulses once at 52080 clocks; busy falls on the next edge.
- Send 0x50, then present 0x47 as soon as ready rises → second start bit begins on the same edge as the first stop bit's end; no idle cycle; two done pulses exactly 52080 clocks apart.
- While 0x47 is shifting and 0x41 is held, assert valid_in with 0xFF → ready=0, 0xFF never transmitted, 0x41 follows 0x47 intact.
- Assert rst mid-way through data bit 3 of 0xA5 → tx=1, busy=0, ready=1 on the next edge; no done pulse; a subsequent 0x00 transmits correctly.
- Boundary bytes 0x00 and 0xFF → eight data bits of 0 and 1 respectively, correct start and stop bits.
- Loop tx into uart_rx at the same parameters, send 0x46, 0x50, 0x47, 0x41 → uart_rx asserts valid four times with d_out matching, in order.
